can_frame_tx: RTL and testbench

- Serialises one CAN 2.0A/2.0B data or remote frame onto the canTX line, one bit per bit-time tick.
- Handles bit stuffing, CRC-15 generation, arbitration-loss detection and ACK-slot checking.
- Is the transmit counterpart of the packetCapture receiver and shares its bus-tick enable (en) and recessive-high tx/rx convention.
- Sits between the host message buffer and the CAN transceiver; tx is wire-ANDed with any local ack driver at top level.

---
 rtl/can_frame_tx_if.sv | 36 +++
 rtl/can_frame_tx.sv | 197 +++++++++++++++++++
 tb/tb_can_frame_tx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/can_frame_tx_if.sv
// rtl/can_frame_tx_if.sv - host/bus signal bundle for the CAN frame transmitter
//
// Purpose: groups the bit-tick enable, the host message request, the bus
// lines and the status pulses of can_frame_tx.
// Modports:
//   master - host/bus side: drives en, start, ext, id, rtr, dlc, data, rx;
//            observes tx, busy, done, arb_lost, ack_err, bit_err.
//   slave  - the transmitter itself (directions reversed).
interface can_frame_tx_if #(
  parameter int LEN_DATA = 64
);
  logic                en;
  logic                start;
  logic                ext;
  logic [28:0]         id;
  logic                rtr;
  logic [3:0]          dlc;
  logic [LEN_DATA-1:0] data;
  logic                rx;
  logic                tx;
  logic                busy;
  logic                done;
  logic                arb_lost;
  logic                ack_err;
  logic                bit_err;

  modport master (
    output en, start, ext, id, rtr, dlc, data, rx,
    input  tx, busy, done, arb_lost, ack_err, bit_err
  );

  modport slave (
    input  en, start, ext, id, rtr, dlc, data, rx,
    output tx, busy, done, arb_lost, ack_err, bit_err
  );
endinterface

// File: rtl/can_frame_tx.sv
// rtl/can_frame_tx.sv - CAN 2.0A/2.0B data/remote frame serialiser
//
// Purpose: sends one frame on tx (1 = recessive), one bus bit per clk with
// en=1, with bit stuffing, CRC-15, arbitration-loss detection and ACK check.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - can_frame_tx_if.slave: en (bit tick), start/ext/id/rtr/dlc/data
//          (message, latched on start in IDLE), rx (bus level), tx, busy,
//          done/arb_lost/ack_err/bit_err (one-clk pulses)
// Optional feature macro: CAN_TX_BIT_ERR_EN enables bit monitoring outside
// the arbitration window and ACK slot (SOF through EOF); without it bit_err
// stays 0 and such mismatches are ignored.
module can_frame_tx #(
  parameter int          LEN_DATA = 64,
  parameter int          LEN_EOF  = 7,
  parameter int          LEN_IFS  = 3,
  parameter logic [14:0] CRC_POLY = 15'h4599
) (
  input  logic              clk,
  input  logic              rst,
  can_frame_tx_if.slave     bus
);

`ifdef CAN_TX_BIT_ERR_EN
  localparam bit BIT_CHK = 1'b1;
`else
  localparam bit BIT_CHK = 1'b0;
`endif

  // Header = SOF..last data bit, left aligned; std frames pad the tail.
  localparam int         HDR_W     = 39 + LEN_DATA;
  localparam int         MAX_BYTES = LEN_DATA / 8;
  localparam logic [7:0] EOF_END   = 8'(3 + LEN_EOF);
  localparam logic [7:0] TAIL_LAST = 8'(3 + LEN_EOF + LEN_IFS - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_CRC, S_TAIL} state_t;

  state_t           state, state_n;
  logic             tx_q, tx_n;
  logic [HDR_W-1:0] sr, sr_n;
  logic [7:0]       pos, pos_n;          // index of last unstuffed bit in field
  logic [14:0]      crc, crc_n;
  logic [2:0]       scnt, scnt_n;        // run length of equal transmitted bits
  logic [7:0]       hdr_len, hdr_len_n;
  logic [7:0]       arb_end, arb_end_n;  // last header index in arbitration
  logic             done_q, done_n, arb_q, arb_n, ack_q, ack_n, berr_q, berr_n;

  logic [HDR_W-1:0] std_vec, ext_vec;
  logic [3:0]       nbytes;
  logic             in_arb;
  logic             nxt_bit;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    crc_step = {c[13:0], 1'b0} ^ ((c[14] ^ b) ? CRC_POLY : 15'h0);
  endfunction

  assign std_vec = {1'b0, bus.id[10:0], bus.rtr, 2'b00, bus.dlc, bus.data, {20{1'b0}}};
  assign ext_vec = {1'b0, bus.id[28:18], 2'b11, bus.id[17:0], bus.rtr, 2'b00,
                    bus.dlc, bus.data};
  assign nbytes  = bus.rtr ? 4'd0 :
                   ({1'b0, bus.dlc} > 5'(MAX_BYTES)) ? 4'(MAX_BYTES) : bus.dlc;

  // pos does not move while a stuff bit is on the bus, so stuff bits after
  // an arbitration bit inherit that bit's window membership.
  assign in_arb = (state == S_HDR) && (pos >= 8'd1) && (pos <= arb_end);

  always_comb begin
    state_n   = state;
    tx_n      = tx_q;
    sr_n      = sr;
    pos_n     = pos;
    crc_n     = crc;
    scnt_n    = scnt;
    hdr_len_n = hdr_len;
    arb_end_n = arb_end;
    done_n    = 1'b0;
    arb_n     = 1'b0;
    ack_n     = 1'b0;
    berr_n    = 1'b0;
    nxt_bit   = 1'b1;
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (bus.start) begin
          // SOF goes on the bus straight away; crc_step(0, SOF=0) is 0.
          state_n   = S_HDR;
          tx_n      = 1'b0;
          sr_n      = bus.ext ? {ext_vec[HDR_W-2:0], 1'b0} : {std_vec[HDR_W-2:0], 1'b0};
          pos_n     = 8'd0;
          crc_n     = 15'h0;
          scnt_n    = 3'd1;
          hdr_len_n = (bus.ext ? 8'd39 : 8'd19) + {1'b0, nbytes, 3'b000};
          arb_end_n = bus.ext ? 8'd32 : 8'd13;
        end
      end
      S_HDR, S_CRC: begin
        if (bus.en) begin
          if (in_arb && tx_q && !bus.rx) begin
            arb_n   = 1'b1;
            tx_n    = 1'b1;
            state_n = S_IDLE;
          end else if (BIT_CHK && !in_arb && (bus.rx != tx_q)) begin
            berr_n  = 1'b1;
            tx_n    = 1'b1;
            state_n = S_IDLE;
          end else if (scnt == 3'd5) begin
            // Checked before the end of CRC so a pending stuff bit after
            // CRC[0] still goes out ahead of the delimiter.
            tx_n   = ~tx_q;
            scnt_n = 3'd1;
          end else if (state == S_CRC && pos == 8'd14) begin
            state_n = S_TAIL;
            pos_n   = 8'd0;
            tx_n    = 1'b1;
          end else begin
            if (state == S_HDR && (pos + 8'd1) < hdr_len) begin
              nxt_bit = sr[HDR_W-1];
              sr_n    = {sr[HDR_W-2:0], 1'b0};
              pos_n   = pos + 8'd1;
              crc_n   = crc_step(crc, nxt_bit);
            end else begin
              // The finished CRC register is shifted out MSB first.
              nxt_bit = crc[14];
              crc_n   = {crc[13:0], 1'b0};
              pos_n   = (state == S_HDR) ? 8'd0 : pos + 8'd1;
              state_n = S_CRC;
            end
            tx_n   = nxt_bit;
            scnt_n = (nxt_bit == tx_q) ? scnt + 3'd1 : 3'd1;
          end
        end
      end
      S_TAIL: begin
        // pos: 0 CRCDEL, 1 ACK, 2 ACKDEL, then EOF, then IFS; tx stays 1.
        if (bus.en) begin
          if (pos == 8'd1) begin
            if (bus.rx) begin
              ack_n   = 1'b1;
              state_n = S_IDLE;
            end else begin
              pos_n = pos + 8'd1;
            end
          end else if (BIT_CHK && pos < EOF_END && (bus.rx != tx_q)) begin
            berr_n  = 1'b1;
            tx_n    = 1'b1;
            state_n = S_IDLE;
          end else if (pos == TAIL_LAST) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            pos_n = pos + 8'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      tx_q    <= 1'b1;
      sr      <= '0;
      pos     <= 8'd0;
      crc     <= 15'h0;
      scnt    <= 3'd0;
      hdr_len <= 8'd0;
      arb_end <= 8'd0;
      done_q  <= 1'b0;
      arb_q   <= 1'b0;
      ack_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state   <= state_n;
      tx_q    <= tx_n;
      sr      <= sr_n;
      pos     <= pos_n;
      crc     <= crc_n;
      scnt    <= scnt_n;
      hdr_len <= hdr_len_n;
      arb_end <= arb_end_n;
      done_q  <= done_n;
      arb_q   <= arb_n;
      ack_q   <= ack_n;
      berr_q  <= berr_n;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_q;
  assign bus.arb_lost = arb_q;
  assign bus.ack_err  = ack_q;
  assign bus.bit_err  = berr_q;

endmodule

// File: tb/tb_can_frame_tx.sv
// tb/tb_can_frame_tx.sv - self-checking bench for can_frame_tx
module tb_can_frame_tx;
  localparam int LEN_EOF = 7;
  localparam int LEN_IFS = 3;

  logic clk = 1'b0;
  logic rst;
  logic rx_low;
  bit   biterr_on;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  can_frame_tx_if bus();
  assign bus.rx = rx_low ? 1'b0 : bus.tx;

  can_frame_tx dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference frame: unstuffed header bits, transmitted (stuffed) stream,
  // and for each transmitted bit its unstuffed index (-1 = stuff bit).
  bit          u_q[$];
  bit          exp_q[$];
  int          uidx_q[$];
  logic [14:0] m_crc;
  int          ack_k;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic build(input bit e, input logic [28:0] i, input bit r,
                       input logic [3:0] d, input logic [63:0] dat);
    bit          div[$];
    logic [15:0] g;
    int          nb, run;
    bit          b, last;
    u_q.delete(); exp_q.delete(); uidx_q.delete();
    u_q.push_back(1'b0);
    if (e) begin
      for (int k = 28; k >= 18; k--) u_q.push_back(i[k]);
      u_q.push_back(1'b1); u_q.push_back(1'b1);
      for (int k = 17; k >= 0; k--) u_q.push_back(i[k]);
      u_q.push_back(r); u_q.push_back(1'b0); u_q.push_back(1'b0);
    end else begin
      for (int k = 10; k >= 0; k--) u_q.push_back(i[k]);
      u_q.push_back(r); u_q.push_back(1'b0); u_q.push_back(1'b0);
    end
    for (int k = 3; k >= 0; k--) u_q.push_back(d[k]);
    nb = r ? 0 : ((d > 8) ? 8 : int'(d));
    for (int k = 0; k < nb * 8; k++) u_q.push_back(dat[63-k]);
    // CRC as remainder of M(x)*x^15 divided by x^15 + CRC_POLY (long division).
    g = 16'hC599;
    div = u_q;
    for (int j = 0; j < 15; j++) div.push_back(1'b0);
    for (int j = 0; j + 15 < div.size(); j++)
      if (div[j]) for (int t = 0; t < 16; t++) div[j+t] = div[j+t] ^ g[15-t];
    for (int t = 0; t < 15; t++) m_crc[14-t] = div[div.size()-15+t];
    run = 0; last = 1'b1;
    for (int j = 0; j < u_q.size() + 15; j++) begin
      b = (j < u_q.size()) ? u_q[j] : m_crc[14-(j-u_q.size())];
      exp_q.push_back(b); uidx_q.push_back(j);
      run = (run > 0 && b == last) ? run + 1 : 1;
      last = b;
      if (run == 5) begin
        exp_q.push_back(!b); uidx_q.push_back(-1);
        last = !b; run = 1;
      end
    end
    for (int j = 0; j < 3 + LEN_EOF + LEN_IFS; j++) begin
      if (j == 1) ack_k = exp_q.size();
      exp_q.push_back(1'b1); uidx_q.push_back(u_q.size() + 15 + j);
    end
  endtask

  // mode: 0 ACKed, 1 no ACK, 2 rx low at tick ab (arbitration),
  //       3 reset at tick ab, 4 rx low at tick ab (bit monitoring)
  task automatic run_frame(input int mode, input int ab, input bit e, input logic [28:0] i,
                           input bit r, input logic [3:0] d, input logic [63:0] dat,
                           input string tag);
    int       k;
    bit       fin, go, term;
    logic [3:0] ep;
    build(e, i, r, d, dat);
    @(negedge clk);
    bus.ext = e; bus.id = i; bus.rtr = r; bus.dlc = d; bus.data = dat;
    bus.start = 1'b1; bus.en = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.start = 1'b0;
    k = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      chk({tag, " tx"}, bus.tx, exp_q[k]);
      chk({tag, " busy"}, bus.busy, 1);
      chk({tag, " pulses"}, {bus.done, bus.arb_lost, bus.ack_err, bus.bit_err}, 0);
      if (mode == 3 && k == ab) begin
        rst = 1'b1;
        #1;
        chk({tag, " rst tx"}, bus.tx, 1);
        chk({tag, " rst busy"}, bus.busy, 0);
        @(negedge clk);
        chk({tag, " rst pulses"}, {bus.done, bus.arb_lost, bus.ack_err, bus.bit_err}, 0);
        rst = 1'b0;
        fin = 1'b1;
      end else begin
        rx_low = (mode != 1 && k == ack_k) || ((mode == 2 || mode == 4) && k == ab);
        go = ($urandom_range(0, 3) != 0);
        bus.en = go;
        bus.start = ($urandom_range(0, 5) == 0);
        bus.id = 29'($urandom); bus.dlc = 4'($urandom); bus.ext = 1'($urandom);
        bus.data = {$urandom, $urandom};
        @(negedge clk);
        rx_low = 1'b0; bus.start = 1'b0;
        if (go) begin
          term = 1'b1;
          if (mode == 1 && k == ack_k) ep = 4'b0010;
          else if (mode == 2 && k == ab) ep = 4'b0100;
          else if (mode == 4 && biterr_on && k == ab) ep = 4'b0001;
          else if (k == exp_q.size() - 1) ep = 4'b1000;
          else term = 1'b0;
          if (term) begin
            chk({tag, " end pulse"}, {bus.done, bus.arb_lost, bus.ack_err, bus.bit_err}, ep);
            chk({tag, " end busy"}, bus.busy, 0);
            chk({tag, " end tx"}, bus.tx, 1);
            bus.en = 1'($urandom);
            @(negedge clk);
            chk({tag, " pulse width"}, {bus.done, bus.arb_lost, bus.ack_err, bus.bit_err}, 0);
            chk({tag, " idle busy"}, bus.busy, 0);
            fin = 1'b1;
          end else begin
            k++;
          end
        end
      end
    end
    if (!fin) chk({tag, " timeout"}, 1, 0);
  endtask

  initial begin
    int          ab;
    logic [63:0] d8;
    logic [3:0]  dl;
    bus.en = 1'b0; bus.start = 1'b0; bus.ext = 1'b0; bus.id = '0;
    bus.rtr = 1'b0; bus.dlc = '0; bus.data = '0;
    rx_low = 1'b0;
    biterr_on = 1'b0;
`ifdef CAN_TX_BIT_ERR_EN
    biterr_on = 1'b1;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx", bus.tx, 1);
    chk("reset busy", bus.busy, 0);
    chk("reset pulses", {bus.done, bus.arb_lost, bus.ack_err, bus.bit_err}, 0);
    rst = 1'b0;

    // Hand-derived anchors for the reference model.
    build(1'b0, 29'h0, 1'b0, 4'd0, 64'h0);
    chk("pin zero length", exp_q.size(), 53);
    chk("pin zero stuff5", exp_q[5], 1);
    chk("pin zero stuff11", exp_q[11], 1);
    chk("pin zero crc", m_crc, 0);
    chk("pin zero ack index", ack_k, 41);
    build(1'b0, 29'h123, 1'b0, 4'd1, 64'hAA00_0000_0000_0000);
    chk("pin stdA unstuffed", u_q.size() + 15 + 13, 55);
    build(1'b1, 29'h1ABCDEF, 1'b1, 4'hF, 64'h0123_4567_89AB_CDEF);
    chk("pin ext srr", u_q[12], 1);
    chk("pin ext ide", u_q[13], 1);
    chk("pin ext dlc", {u_q[35], u_q[36], u_q[37], u_q[38]}, 4'hF);
    chk("pin ext no data", u_q.size(), 39);

    run_frame(0, -1, 1'b0, 29'h123, 1'b0, 4'd1, 64'hAA00_0000_0000_0000, "stdA");
    run_frame(0, -1, 1'b0, 29'h0, 1'b0, 4'd0, 64'h0, "zero");
    run_frame(0, -1, 1'b1, 29'h1ABCDEF, 1'b1, 4'hF, {$urandom, $urandom}, "extrtr");
    run_frame(2, 3, 1'b0, 29'h7FF, 1'b0, 4'd2, {$urandom, $urandom}, "arb");
    run_frame(1, -1, 1'b0, 29'h555, 1'b0, 4'd3, {$urandom, $urandom}, "noack");

    d8 = {$urandom, $urandom};
    build(1'b0, 29'h2A5, 1'b0, 4'd8, d8);
    ab = -1;
    for (int k = 0; k < exp_q.size(); k++) if (ab < 0 && uidx_q[k] == 19 + 26) ab = k;
    run_frame(3, ab, 1'b0, 29'h2A5, 1'b0, 4'd8, d8, "rst");
    run_frame(0, -1, 1'b0, 29'h2A5, 1'b0, 4'd8, d8, "afterrst");

    build(1'b0, 29'h123, 1'b0, 4'd1, 64'hAA00_0000_0000_0000);
    ab = -1;
    for (int k = 0; k < exp_q.size(); k++)
      if (ab < 0 && uidx_q[k] >= u_q.size() && uidx_q[k] < u_q.size() + 15 && exp_q[k])
        ab = k;
    run_frame(4, ab, 1'b0, 29'h123, 1'b0, 4'd1, 64'hAA00_0000_0000_0000, "crcrx");

    for (int n = 0; n < 10; n++) begin
      dl = 4'($urandom);
      run_frame(0, -1, 1'($urandom), 29'($urandom), ($urandom_range(0, 3) == 0), dl,
                {$urandom, $urandom}, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
